// File: rtl/ps2_rx_ctrl.sv
// ----------------------------------------------------------------------------
// ps2_rx_ctrl
//
// PS/2 keyboard receive controller. It synchronizes the raw PS/2 clock and data
// pads and detects falling edges of the PS/2 clock. It drives an external
// 11-bit shift register through shift_en/din/sr_clear. After 11 bits it checks
// the assembled frame (start, odd parity, stop). It then decodes the 0xF0
// (break) and 0xE0 (extended) prefixes into flags that qualify the next scan
// code.
//
// Optional feature (macro PS2_RX_TIMEOUT_EN): an inter-edge watchdog aborts a
// frame when no PS/2 falling edge arrives for TIMEOUT_CYCLES sys_clk cycles
// while receiving. Without the macro no counter is built and a partial frame
// waits indefinitely.
//
// Parameters
//   TIMEOUT_CYCLES  sys_clk cycles allowed between PS/2 falling edges in a frame
//   TO_W            width of the watchdog counter
//
// Ports
//   sys_clk     in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   ps2_clk     in   raw PS/2 clock pad (asynchronous)
//   ps2_data    in   raw PS/2 data pad (asynchronous)
//   frame_q     in   external shift register: [0] start, [8:1] data LSB first,
//                    [9] parity, [10] stop
//   shift_en    out  one-cycle pulse, shift register loads din
//   din         out  synchronized data bit, valid with shift_en
//   sr_clear    out  one-cycle pulse, clears the shift register
//   code        out  last decoded scan code
//   code_valid  out  one-cycle pulse, code/brk/ext valid
//   brk         out  code was preceded by 0xF0
//   ext         out  code was preceded by 0xE0
//   frame_err   out  one-cycle pulse on a rejected or aborted frame
// ----------------------------------------------------------------------------
module ps2_rx_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned TO_W           = 16
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic [10:0] frame_q,
    output logic        shift_en,
    output logic        din,
    output logic        sr_clear,
    output logic [7:0]  code,
    output logic        code_valid,
    output logic        brk,
    output logic        ext,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [3:0] FRAME_BITS = 4'd11;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;

    state_t state_q, state_d;

    // Two-stage synchronizers plus a history flop for edge detection. All of
    // them reset to 1 (PS/2 idle level) so releasing reset with an idle bus
    // does not fake a falling edge.
    logic ps2c_meta_q, ps2c_sync_q, ps2c_prev_q;
    logic ps2d_meta_q, ps2d_sync_q;

    logic [3:0] bitcnt_q, bitcnt_d;
    logic       brk_flag_q, brk_flag_d;
    logic       ext_flag_q, ext_flag_d;

    logic       shift_en_q, shift_en_d;
    logic       din_q, din_d;
    logic       sr_clear_q, sr_clear_d;
    logic [7:0] code_q, code_d;
    logic       code_valid_q, code_valid_d;
    logic       brk_q, brk_d;
    logic       ext_q, ext_d;
    logic       frame_err_q, frame_err_d;

    logic fall_edge;
    logic edge_ok;
    logic frame_good;
    logic to_fire;

    assign fall_edge = ps2c_prev_q & ~ps2c_sync_q;

    // Edges seen while the frame is being judged, or while the shift register
    // is being cleared, are dropped so a clear can never collide with a shift.
    assign edge_ok = fall_edge && (state_q != CHECK) && !sr_clear_q;

    assign frame_good = ~frame_q[0] & frame_q[10] & (^frame_q[9:1]);

`ifdef PS2_RX_TIMEOUT_EN
    logic [TO_W-1:0] to_q, to_d;
    logic [TO_W-1:0] to_inc;
    logic            to_active;

    // The counter only runs while waiting for the next bit of a frame; the
    // cycle that moves a full frame on to CHECK is not a waiting cycle.
    assign to_active = (state_q == RECV) && (bitcnt_q != FRAME_BITS) && !edge_ok;
    assign to_inc    = to_q + 1'b1;
    assign to_fire   = to_active && (to_inc == TO_W'(TIMEOUT_CYCLES));
    assign to_d      = (to_active && !to_fire) ? to_inc : '0;

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end
`else
    // Watchdog absent: the parameters are still referenced here so the
    // interface stays identical across both builds.
    logic [TO_W-1:0] unused_timeout_cfg;
    assign unused_timeout_cfg = TO_W'(TIMEOUT_CYCLES);
    assign to_fire            = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ps2c_meta_q  <= 1'b1;
            ps2c_sync_q  <= 1'b1;
            ps2c_prev_q  <= 1'b1;
            ps2d_meta_q  <= 1'b1;
            ps2d_sync_q  <= 1'b1;
            bitcnt_q     <= 4'd0;
            brk_flag_q   <= 1'b0;
            ext_flag_q   <= 1'b0;
            shift_en_q   <= 1'b0;
            din_q        <= 1'b0;
            sr_clear_q   <= 1'b0;
            code_q       <= 8'h00;
            code_valid_q <= 1'b0;
            brk_q        <= 1'b0;
            ext_q        <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ps2c_meta_q  <= ps2_clk;
            ps2c_sync_q  <= ps2c_meta_q;
            ps2c_prev_q  <= ps2c_sync_q;
            ps2d_meta_q  <= ps2_data;
            ps2d_sync_q  <= ps2d_meta_q;
            bitcnt_q     <= bitcnt_d;
            brk_flag_q   <= brk_flag_d;
            ext_flag_q   <= ext_flag_d;
            shift_en_q   <= shift_en_d;
            din_q        <= din_d;
            sr_clear_q   <= sr_clear_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            brk_q        <= brk_d;
            ext_q        <= ext_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        brk_flag_d   = brk_flag_q;
        ext_flag_d   = ext_flag_q;
        shift_en_d   = 1'b0;
        din_d        = 1'b0;
        sr_clear_d   = 1'b0;
        code_d       = code_q;
        code_valid_d = 1'b0;
        brk_d        = brk_q;
        ext_d        = ext_q;
        frame_err_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Only a low data bit can be a start bit; a high bit on an
                // edge here is line noise or a leftover and is ignored.
                if (edge_ok && !ps2d_sync_q) begin
                    shift_en_d = 1'b1;
                    din_d      = 1'b0;
                    bitcnt_d   = 4'd1;
                    state_d    = RECV;
                end
            end

            RECV: begin
                if (bitcnt_q == FRAME_BITS) begin
                    // The 11th bit lands in the shift register at the end of
                    // this cycle, so the frame is judged one cycle later.
                    state_d = CHECK;
                end else if (edge_ok) begin
                    shift_en_d = 1'b1;
                    din_d      = ps2d_sync_q;
                    bitcnt_d   = bitcnt_q + 4'd1;
                end else if (to_fire) begin
                    frame_err_d = 1'b1;
                    sr_clear_d  = 1'b1;
                    brk_flag_d  = 1'b0;
                    ext_flag_d  = 1'b0;
                    bitcnt_d    = 4'd0;
                    state_d     = IDLE;
                end
            end

            CHECK: begin
                state_d    = IDLE;
                sr_clear_d = 1'b1;
                bitcnt_d   = 4'd0;
                if (frame_good) begin
                    if (frame_q[8:1] == CODE_BRK) begin
                        brk_flag_d = 1'b1;
                    end else if (frame_q[8:1] == CODE_EXT) begin
                        ext_flag_d = 1'b1;
                    end else begin
                        code_d       = frame_q[8:1];
                        brk_d        = brk_flag_q;
                        ext_d        = ext_flag_q;
                        code_valid_d = 1'b1;
                        brk_flag_d   = 1'b0;
                        ext_flag_d   = 1'b0;
                    end
                end else begin
                    // A corrupt frame also invalidates any pending prefix.
                    frame_err_d = 1'b1;
                    brk_flag_d  = 1'b0;
                    ext_flag_d  = 1'b0;
                end
            end

            default: begin
                state_d  = IDLE;
                bitcnt_d = 4'd0;
            end
        endcase
    end

    assign shift_en   = shift_en_q;
    assign din        = din_q;
    assign sr_clear   = sr_clear_q;
    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign brk        = brk_q;
    assign ext        = ext_q;
    assign frame_err  = frame_err_q;

endmodule

// File: doc/ps2_rx_ctrl.md
PS2_RX_CTRL -- requirements
Module: ps2_rx_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, sys_clk cycles allowed between PS/2 falling edges inside a frame.
REQ-002 Parameter TO_W, default 16, width of the timeout counter.
REQ-003 sys_clk  in  1  system clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 ps2_clk  in  1  raw PS/2 clock from the pad, asynchronous.
REQ-006 ps2_data  in  1  raw PS/2 data from the pad, asynchronous.
REQ-007 frame_q  in  11  shift register contents; [0] start, [8:1] data LSB-first, [9] parity, [10] stop.
REQ-008 shift_en  out  1  one-cycle pulse; shift register shifts din in.
REQ-009 din  out  1  synchronized data bit, valid while shift_en=1.
REQ-010 sr_clear  out  1  one-cycle pulse; drives the shift register's clear.
REQ-011 code  out  8  last decoded scan code.
REQ-012 code_valid  out  1  one-cycle pulse; code, brk and ext are valid.
REQ-013 brk  out  1  code was preceded by 0xF0.
REQ-014 ext  out  1  code was preceded by 0xE0.
REQ-015 frame_err  out  1  one-cycle pulse on a rejected or aborted frame.

Function
REQ-016 ps2_clk and ps2_data SHALL each pass a 2-FF synchronizer; a falling edge is previous synced clk=1 and current synced clk=0.
REQ-017 On each accepted falling edge, shift_en SHALL pulse one cycle with din = synced ps2_data.
REQ-018 FSM states SHALL be IDLE, RECV and CHECK.
REQ-019 IDLE: an edge with din=0 SHALL shift, set the bit count to 1 and enter RECV; an edge with din=1 SHALL be ignored (no shift_en).
REQ-020 RECV: each edge SHALL shift and increment the bit count; the edge that makes the count 11 SHALL move to CHECK on the next cycle.
REQ-021 CHECK (one cycle): the frame is good iff frame_q[0]=0, frame_q[10]=1 and XOR of frame_q[9:1]=1 (odd parity).
REQ-022 Good frame, data 0xF0: set the brk flag, no code_valid. Data 0xE0: set the ext flag, no code_valid.
REQ-023 Good frame, any other data: code <= data, brk/ext <= flags, code_valid pulses, then both flags clear.
REQ-024 Bad frame: frame_err pulses, no code_valid, both flags clear, code unchanged.
REQ-025 Latency: 11th shift_en in cycle T, CHECK in T+1, code_valid/frame_err and sr_clear in T+2, IDLE in T+2.
REQ-026 Falling edges that occur in CHECK or in a cycle with sr_clear=1 SHALL be dropped; shift_en and sr_clear are never high together.
REQ-027 code, brk and ext SHALL hold their values until the next code_valid.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 When reset=0, immediately: state IDLE, bit count 0, timeout counter 0, synchronizer flops 1, flags 0, all outputs 0.
REQ-030 Reset released mid-frame SHALL discard the partial frame; the next start bit begins a new frame.

Configuration
REQ-031 With PS2_RX_TIMEOUT_EN defined: in RECV, the counter SHALL clear on each edge and increment otherwise.
REQ-032 When the counter reaches TIMEOUT_CYCLES: pulse frame_err and sr_clear together, clear the flags and bit count, return to IDLE.
REQ-033 Without PS2_RX_TIMEOUT_EN: no counter is built, RECV waits indefinitely, and TIMEOUT_CYCLES is unused.

Verification
REQ-034 Frame 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1) -> code=0x1C, code_valid 1 cycle at T+2, brk=0, ext=0, sr_clear at T+2.
REQ-035 Frames F0,1C -> no code_valid after F0; code=0x1C brk=1 ext=0; a following 1C frame gives brk=0.
REQ-036 Frames E0,F0,75 -> a single code_valid with code=0x75, brk=1, ext=1.
REQ-037 0x1C frame with parity bit 1 -> frame_err pulse, no code_valid, flags cleared; stop bit 0 gives the same result.
REQ-038 With the macro defined and TIMEOUT_CYCLES=100: 5 bits then an idle clock -> frame_err and sr_clear 100 cycles after the last edge; next frame 0x1C decodes correctly.
REQ-039 reset=0 after 6 bits -> outputs 0 in the same cycle; after release, frame 0x1C decodes correctly; a din=1 edge in IDLE produces no shift_en.
